// File: rtl/chu_chasing_led_core.sv
// MMIO slot core driving a one-hot chasing LED pattern with programmable rate, enable and bounce/wrap mode.
// Optional CHASE_STEP_CNT_EN adds a read-only 32-bit step counter at address 3.
module chu_chasing_led_core #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] led
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [4:0] POS_LAST = 5'(W - 1);
    localparam logic [4:0] POS_PREV = 5'(W - 2);

    logic         en_q, en_d;
    logic         wrap_q, wrap_d;
    logic [31:0]  period_q, period_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [4:0]   pos_q, pos_d;
    dir_e         dir_q, dir_d;
    logic [W-1:0] led_q, led_d;

    logic         ctrl_we, period_we, restart;
    logic [31:0]  period_eff;
    logic         terminal, step;

    // Reads have no side effects, so the strobe is intentionally unused.
    logic unused_read;
    assign unused_read = read;

    assign ctrl_we    = cs && write && (addr == 5'd0);
    assign period_we  = cs && write && (addr == 5'd1);
    assign restart    = ctrl_we && wr_data[2];
    assign period_eff = (period_q == '0) ? 32'd1 : period_q;
    assign terminal   = (cnt_q == period_eff - 32'd1);
    // Any CTRL or PERIOD write pre-empts a step landing on the same edge.
    assign step       = en_q && terminal && !ctrl_we && !period_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            wrap_q   <= 1'b0;
            period_q <= 32'd1;
            cnt_q    <= '0;
            pos_q    <= '0;
            dir_q    <= DIR_UP;
            led_q    <= {{(W-1){1'b0}}, 1'b1};
        end else begin
            en_q     <= en_d;
            wrap_q   <= wrap_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        en_d     = en_q;
        wrap_d   = wrap_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        dir_d    = dir_q;

        if (ctrl_we) begin
            en_d   = wr_data[0];
            wrap_d = wr_data[1];
        end
        if (period_we) begin
            period_d = wr_data;
        end

        if (period_we || restart) begin
            cnt_d = '0;
        end else if (en_q && !ctrl_we) begin
            cnt_d = terminal ? '0 : cnt_q + 32'd1;
        end

        if (restart) begin
            pos_d = '0;
            dir_d = DIR_UP;
        end else if (step) begin
            if (wrap_q) begin
                if (dir_q == DIR_UP) begin
                    pos_d = (pos_q == POS_LAST) ? 5'd0 : pos_q + 5'd1;
                end else begin
                    pos_d = (pos_q == 5'd0) ? POS_LAST : pos_q - 5'd1;
                end
            end else if (dir_q == DIR_UP) begin
                if (pos_q == POS_LAST) begin
                    dir_d = DIR_DOWN;
                    pos_d = POS_PREV;
                end else begin
                    pos_d = pos_q + 5'd1;
                end
            end else begin
                if (pos_q == 5'd0) begin
                    dir_d = DIR_UP;
                    pos_d = 5'd1;
                end else begin
                    pos_d = pos_q - 5'd1;
                end
            end
        end

        led_d = {{(W-1){1'b0}}, 1'b1} << pos_d;
    end

`ifdef CHASE_STEP_CNT_EN
    logic [31:0] steps_q, steps_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    always_comb begin
        steps_d = steps_q;
        if (restart) begin
            steps_d = '0;
        end else if (step) begin
            steps_d = steps_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: rd_data = {30'd0, wrap_q, en_q};
            5'd1: rd_data = period_q;
            5'd2: rd_data = {22'd0, en_q, (dir_q == DIR_DOWN), 3'd0, pos_q};
`ifdef CHASE_STEP_CNT_EN
            5'd3: rd_data = steps_q;
`else
            5'd3: rd_data = '0;
`endif
            default: rd_data = '0;
        endcase
    end

    assign led = led_q;

endmodule

// File: doc/chu_chasing_led_core.md
Name: chu_chasing_led_core

Overview:
- MMIO slot core that consumes one slot's signals from the FPro MMIO controller: chip-select, read/write strobes, 5-bit register address and 32-bit write data. It returns 32-bit read data to the controller's read mux.
- Drives a one-hot "chasing" LED pattern across W LEDs.
- Step rate, enable, bounce/wrap mode and restart are all software-programmable.

Parameters:
W, 16, number of LEDs driven (2..32)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low (core is reset while reset==0)
cs  input  1  slot chip-select from the MMIO controller
read  input  1  bus read strobe
write  input  1  bus write strobe
addr  input  5  register address within the slot
wr_data  input  32  bus write data
rd_data  output  32  bus read data, combinational
led  output  W  LED drive, one-hot

Behaviour:
- Register map (word addresses):
  - 0 CTRL (R/W): bit0 EN, bit1 WRAP (0=bounce, 1=wrap), bit2 RESTART (write-only; self-clears, reads 0).
  - 1 PERIOD (R/W, 32 bit): clocks per step. A value of 0 is treated as 1.
  - 2 STATUS (RO): [4:0] POS, [8] DIR (0=up, 1=down), [9] EN.
  - Other addresses read 0.
- Write enable is cs && write && addr==n. The register updates on that clk edge. Writes to RO or unmapped addresses are ignored.
- Read: rd_data = mux(addr) of the current register values, with zero cycles of latency. The read strobe has no side effects.
- Reset values: CTRL=0, PERIOD=0x0000_0001, POS=0, DIR=up, prescaler count=0, led=1 (LED0 on), rd_data follows the mux.
- Prescaler:
  - When EN=1, cnt increments each clk.
  - When cnt == max(PERIOD,1)-1: cnt<=0 and a step pulse fires for one cycle.
  - When EN=0, cnt holds and no steps occur. POS and DIR hold.
  - A write to PERIOD clears cnt in the same edge.
- Direction FSM states: UP and DOWN. On a step:
  - Bounce, UP: if POS==W-1, go to DOWN and POS<=W-2; else POS+1.
  - Bounce, DOWN: if POS==0, go to UP and POS<=1; else POS-1.
  - Wrap, UP: POS<=(POS==W-1)?0:POS+1.
  - Wrap, DOWN: POS<=(POS==0)?W-1:POS-1. DIR is unchanged in wrap mode.
- led = 1<<POS, registered alongside POS. Exactly one bit is set at all times.
- RESTART, or the CTRL write itself, takes priority over a step in the same cycle. Writing CTRL with bit2=1 sets POS=0, DIR=up and cnt=0. EN/WRAP take the written values.
- Changing WRAP while running keeps POS/DIR. The next step uses the new mode.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Release takes effect on the next clk.
- A PERIOD write coincident with a terminal count: the write wins, cnt<=0 and no step fires that cycle.

Optional Feature:
- Macro CHASE_STEP_CNT_EN.
- When defined: a 32-bit free-running step counter at address 3 (RO) increments on every step pulse and wraps 0xFFFF_FFFF->0. It is cleared by reset and RESTART.
- When undefined: address 3 reads 0 and no counter logic is synthesized.

Test Plan:
- Reset check: hold reset low, then release -> led=0x0001, STATUS=0, CTRL=0, PERIOD=1, rd_data of addr 5 =0.
- Bounce stepping: W=16, PERIOD=4, CTRL=1 -> led shifts every 4 clks through 0x0001..0x8000, then 0x4000 with DIR=1, and returns to 0x0001 after 30 steps.
- Wrap down: PERIOD=1, CTRL=0x3, run to POS=15 -> next step gives POS=0. Force DIR=down via a bounce turnaround, then set WRAP -> POS 0 steps to 15.
- Period 0 and enable gating: PERIOD=0 -> step every clk. Write CTRL=0 at POS=7 -> POS holds at 7 for 20 clks. Re-enable -> stepping resumes from 7.
- Collision cases:
  - CTRL=0x5 written on the cycle a step would fire -> POS=0, DIR=0, no step.
  - A PERIOD write at terminal count -> no step.
  - Async reset pulse mid-step -> led=0x0001 within the same cycle.
- With CHASE_STEP_CNT_EN: PERIOD=2, EN for 20 clks -> addr3 reads 10. RESTART -> 0. Without the macro, addr3 reads 0.
